// File: rtl/mips_mem_responder_if.sv
// Processor/preload bus between the MIPS core side (master) and the memory responder (slave).
// Carries read/write strobes, preload port and the responder's status outputs.
interface mips_mem_responder_if #(
  parameter int WIDTH   = 8,
  parameter int CNTBITS = 16
);
  logic               memread;
  logic               memwrite;
  logic [WIDTH-1:0]   adr;
  logic [WIDTH-1:0]   writedata;
  logic [WIDTH-1:0]   memdata;
  logic               load_en;
  logic [WIDTH-1:0]   load_adr;
  logic [WIDTH-1:0]   load_data;
  logic [WIDTH-1:0]   result;
  logic               done;
  logic               pass;
  logic               timeout;
  logic               overwrite;
  logic [CNTBITS-1:0] wr_count;

  modport master (
    output memread, memwrite, adr, writedata, load_en, load_adr, load_data,
    input  memdata, result, done, pass, timeout, overwrite, wr_count
  );

  modport slave (
    input  memread, memwrite, adr, writedata, load_en, load_adr, load_data,
    output memdata, result, done, pass, timeout, overwrite, wr_count
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Memory responder: zero-latency reads, single-edge writes, memory-mapped result register.
// Status FSM (IDLE/RUN/DONE/TIMEOUT) grades the first result write; no backpressure, always ready.
module mips_mem_responder #(
  parameter int                 WIDTH      = 8,
  parameter logic [WIDTH-1:0]   RESULT_ADR = 8'hFF,
  parameter logic [WIDTH-1:0]   EXPECTED   = 8'h0D,
  parameter int                 TIMEOUT    = 300,
  parameter int                 CNTBITS    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_t;

  state_t             state;
  logic [CNTBITS-1:0] cycle_cnt;
  logic [WIDTH-1:0]   mem [0:(2**WIDTH)-1];

  logic result_wr;
  logic array_wr;

  assign result_wr = bus.memwrite && (bus.adr == RESULT_ADR);
  assign array_wr  = bus.memwrite && (bus.adr != RESULT_ADR);

  // memread only qualifies external monitoring; the read path ignores it.
  logic unused_memread;
  assign unused_memread = bus.memread;

  assign bus.memdata = (bus.adr == RESULT_ADR) ? bus.result : mem[bus.adr];

  // Array is never cleared by reset so a preloaded program survives a restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (bus.load_en) mem[bus.load_adr] <= bus.load_data;
    end else if (array_wr) begin
      mem[bus.adr] <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cycle_cnt     <= '0;
      bus.result    <= '0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.overwrite <= 1'b0;
      bus.wr_count  <= '0;
    end else begin
      if (bus.memwrite && (bus.wr_count != '1))
        bus.wr_count <= bus.wr_count + 1'b1;

      case (state)
        ST_IDLE: state <= ST_RUN;
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          // A result write on the timeout edge still counts as completion.
          if (result_wr) begin
            bus.result <= bus.writedata;
            bus.pass   <= (bus.writedata == EXPECTED);
            bus.done   <= 1'b1;
            state      <= ST_DONE;
          end else if (cycle_cnt == CNTBITS'(TIMEOUT - 1)) begin
            bus.timeout <= 1'b1;
            state       <= ST_TIMEOUT;
          end
        end
        ST_DONE: begin
          if (result_wr) bus.overwrite <= 1'b1;
        end
        ST_TIMEOUT: begin
          if (result_wr) bus.result <= bus.writedata;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
